// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-cycle restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 64;
  // Helpers work on a wide container; callers sign-extend in and truncate out.
  localparam int unsigned DIV_MAX_W = 128;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

  typedef logic [DIV_MAX_W-1:0] div_wide_t;

  function automatic div_wide_t neg2c(input div_wide_t value);
    return ~value + div_wide_t'(1);
  endfunction

  function automatic div_wide_t abs_val(input div_wide_t value, input logic is_signed);
    return (is_signed && value[DIV_MAX_W-1]) ? neg2c(value) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, keep or restore.
module div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The sign of the WIDTH+1-bit trial is the compare; on success the difference fits in WIDTH bits.
  always_comb begin
    shifted = {rem, q_msb};
    q_bit   = (shifted >= {1'b0, divisor_mag});
    diff    = shifted[WIDTH-1:0] - divisor_mag;
    new_rem = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] rem, rem_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] dvsr, dvsr_next;
  logic             sign_q, sign_q_next;
  logic             sign_r, sign_r_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             div_by_zero_next, busy_next, done_next;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem),
    .q_msb       (q[WIDTH-1]),
    .divisor_mag (dvsr),
    .new_rem     (step_rem),
    .q_bit       (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvsr        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rem         <= rem_next;
      q           <= q_next;
      dvsr        <= dvsr_next;
      sign_q      <= sign_q_next;
      sign_r      <= sign_r_next;
      busy        <= busy_next;
      done        <= done_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= div_by_zero_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    rem_next         = rem;
    q_next           = q;
    dvsr_next        = dvsr;
    sign_q_next      = sign_q;
    sign_r_next      = sign_r;
    quotient_next    = quotient;
    remainder_next   = remainder;
    div_by_zero_next = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_next    = '0;
            remainder_next   = dividend;
            div_by_zero_next = 1'b1;
            state_next       = DONE;
          end else begin
            // The quotient register starts out holding the dividend magnitude and is shifted out MSB-first.
            q_next      = WIDTH'(abs_val(DIV_MAX_W'($signed(dividend)), is_signed));
            dvsr_next   = WIDTH'(abs_val(DIV_MAX_W'($signed(divisor)), is_signed));
            sign_q_next = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r_next = is_signed & dividend[WIDTH-1];
            rem_next    = '0;
            cnt_next    = CNT_W'(WIDTH);
            state_next  = RUN;
          end
        end
      end
      RUN: begin
        rem_next = step_rem;
        q_next   = {q[WIDTH-2:0], step_bit};
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = FIX;
      end
      FIX: begin
        quotient_next    = sign_q ? WIDTH'(neg2c(DIV_MAX_W'(q))) : q;
        remainder_next   = sign_r ? WIDTH'(neg2c(DIV_MAX_W'(rem))) : rem;
        div_by_zero_next = 1'b0;
        state_next       = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN) || (state_next == FIX);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=64).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Drive start for one edge (edge 0); returns #1 into cycle 1.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Observe cycles 1..n: first done cycle, number of busy cycles and done pulses.
  task automatic watch(input int n, output int done_cyc, output int busy_n, output int done_n);
    done_cyc = -1;
    busy_n   = 0;
    done_n   = 0;
    for (int c = 1; c <= n; c++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 64'd0 || remainder !== 64'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b dbz=%b q=%h r=%h required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_udiv();
    int dc, bn, dn;
    issue(64'd100, 64'd7, 1'b0);
    watch(70, dc, bn, dn);
    checks++;
    if (dc !== 66) begin failures++; $display("FAIL udiv_done_cycle got %0d required 66", dc); end
    checks++;
    if (bn !== 65 || dn !== 1) begin
      failures++; $display("FAIL udiv_handshake busy_cycles=%0d dones=%0d required 65 and 1", bn, dn);
    end
    checks++;
    if (quotient !== 64'd14 || remainder !== 64'd2 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL udiv_result q=%0d r=%0d dbz=%b required 14 2 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_sdiv();
    int dc, bn, dn;
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    watch(70, dc, bn, dn);
    checks++;
    if (dc !== 66 || dn !== 1) begin failures++; $display("FAIL sdiv_neg_done cycle=%0d dones=%0d required 66 and 1", dc, dn); end
    checks++;
    if (quotient !== 64'hFFFF_FFFF_FFFF_FFFD || remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL sdiv_neg_dividend q=%h r=%h required fffffffffffffffd ffffffffffffffff", quotient, remainder);
    end
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    watch(70, dc, bn, dn);
    checks++;
    if (quotient !== 64'hFFFF_FFFF_FFFF_FFFD || remainder !== 64'd1 || dc !== 66) begin
      failures++; $display("FAIL sdiv_neg_divisor q=%h r=%h cycle=%0d required fffffffffffffffd 1 66", quotient, remainder, dc);
    end
  endtask

  task automatic test_div_by_zero();
    int dc, bn, dn;
    issue(64'h1234, 64'd0, 1'b0);
    watch(5, dc, bn, dn);
    checks++;
    if (dc !== 1 || bn !== 0 || dn !== 1) begin
      failures++; $display("FAIL dbz_timing done_cycle=%0d busy_cycles=%0d dones=%0d required 1 0 1", dc, bn, dn);
    end
    checks++;
    if (quotient !== 64'd0 || remainder !== 64'h1234 || div_by_zero !== 1'b1) begin
      failures++; $display("FAIL dbz_result q=%h r=%h dbz=%b required 0 1234 1", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_overflow();
    int dc, bn, dn;
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    watch(70, dc, bn, dn);
    checks++;
    if (dc !== 66) begin failures++; $display("FAIL ovf_done_cycle got %0d required 66", dc); end
    checks++;
    if (quotient !== 64'h8000_0000_0000_0000 || remainder !== 64'd0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL ovf_result q=%h r=%h dbz=%b required 8000000000000000 0 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int dc, bn, dn;
    dc = -1;
    dn = 0;
    issue(64'd100, 64'd7, 1'b0);
    for (int c = 1; c <= 70; c++) begin
      if (c == 10) begin dividend = 64'd50; divisor = 64'd5; start = 1'b1; end
      if (c == 11) start = 1'b0;
      if (c == 67) start = 1'b0;
      if (done) begin
        dn++;
        if (dc < 0) dc = c;
        dividend = 64'd50; divisor = 64'd5; start = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (dc !== 66 || dn !== 1) begin failures++; $display("FAIL b2b_ignored_starts done_cycle=%0d dones=%0d required 66 1", dc, dn); end
    checks++;
    if (quotient !== 64'd14 || remainder !== 64'd2) begin
      failures++; $display("FAIL b2b_first_result q=%0d r=%0d required 14 2", quotient, remainder);
    end
    issue(64'd50, 64'd5, 1'b0);
    watch(70, dc, bn, dn);
    checks++;
    if (dc !== 66 || dn !== 1 || quotient !== 64'd10 || remainder !== 64'd0) begin
      failures++; $display("FAIL b2b_second cycle=%0d dones=%0d q=%0d r=%0d required 66 1 10 0", dc, dn, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int dc, bn, dn;
    issue(64'd100, 64'd7, 1'b0);
    repeat (29) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || quotient !== 64'd10) begin
      failures++; $display("FAIL mid_run_hold busy=%b q=%0d required 1 10", busy, quotient);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 64'd0 || remainder !== 64'd0) begin
      failures++; $display("FAIL mid_reset_outputs busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                           busy, done, div_by_zero, quotient, remainder);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    watch(70, dc, bn, dn);
    checks++;
    if (dn !== 0 || bn !== 0) begin failures++; $display("FAIL mid_reset_no_done dones=%0d busy_cycles=%0d required 0 0", dn, bn); end
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    watch(70, dc, bn, dn);
    checks++;
    if (dc !== 66 || quotient !== 64'hFFFF_FFFF_FFFF_FFFF || remainder !== 64'd0) begin
      failures++; $display("FAIL post_reset_allones cycle=%0d q=%h r=%h required 66 ffffffffffffffff 0", dc, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_udiv();
    test_sdiv();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle integer divider for the EX stage. It is the subtract-based counterpart of the adder datapath and serves LEGv8 UDIV/SDIV.
- Restoring algorithm: one quotient bit per cycle, with a start/busy/done handshake.
- The hazard unit stalls the pipeline while busy is high and captures the quotient when done pulses.

Parameters:
- WIDTH, 64, operand/result width in bits (must be ≥ 2).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- is_signed  input  1  1 = SDIV semantics, 0 = UDIV; captured with start
- dividend  input  WIDTH  numerator; captured with start
- divisor  input  WIDTH  denominator; captured with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle pulse; results are valid from then on
- quotient  output  WIDTH  result quotient; held until the next accepted start
- remainder  output  WIDTH  result remainder; held likewise
- div_by_zero  output  1  flag for the last operation; held likewise

Behaviour:
- Reset (async, active-high): state←IDLE. busy, done, quotient, remainder, div_by_zero all ←0. Counter ←0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 with divisor≠0: latch the operands. If signed, latch their magnitudes and record sign_q = sign(dividend)^sign(divisor) and sign_r = sign(dividend).
  - Then load the partial remainder with 0 and the counter with WIDTH, and go to RUN.
  - start=1 with divisor==0: go to DONE next cycle with quotient=0, remainder=dividend, div_by_zero=1, and no RUN. This matches ARMv8 divide-by-zero behaviour.
- RUN, each cycle:
  - {rem,q} shifted left by 1.
  - trial = rem − |divisor| over WIDTH+1 bits.
  - If trial ≥ 0: rem←trial and q[0]←1; else restore, q[0]←0.
  - Counter decrements; when the counter reaches 1 in RUN, the next state is FIX.
- FIX (1 cycle): if signed, negate q when sign_q=1 and negate rem when sign_r=1 (two's complement). Register quotient/remainder, div_by_zero←0. Go to DONE.
- DONE (1 cycle): done=1, busy=0. Go to IDLE.
- busy=1 in RUN and FIX, 0 otherwise.
- Latency: start sampled at edge 0 → done high during cycle WIDTH+2 (66 for WIDTH=64). Divide-by-zero: done high during cycle 1.
- Signed overflow (MIN / −1): quotient=MIN (wraps), remainder=0, div_by_zero=0, full latency.
- Rounding: truncation toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
- Unsigned: operands are used as-is; the sign logic is bypassed.
- start while not IDLE (RUN/FIX/DONE): ignored, with no effect on the in-flight operation. The result registers do not change until FIX/zero-path.
- start in the same cycle done is high: ignored; accepted only in the following IDLE cycle.
- Input changes after acceptance: no effect, since all operands are latched.
- Reset mid-operation: immediate IDLE, all outputs 0, no done pulse.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t
  - default WIDTH constant
  - function abs_val(value, is_signed)
  - function neg2c(value)
- Sub-module div_step, combinational:
  - inputs rem, q_msb, divisor_mag
  - outputs new_rem and q_bit (the WIDTH+1-bit trial subtract/restore)
  - instantiated once in seq_divider.

Test Plan:
- UDIV: dividend=100, divisor=7, is_signed=0 → done at cycle 66; quotient=14, remainder=2, div_by_zero=0; busy high cycles 1–65.
- SDIV: dividend=−7, divisor=2 → quotient=−3 (0xFFFF_FFFF_FFFF_FFFD), remainder=−1. Then dividend=7, divisor=−2 → quotient=−3, remainder=1.
- Divide by zero: dividend=0x1234, divisor=0 → done at cycle 1; quotient=0, remainder=0x1234, div_by_zero=1, busy never high.
- Signed overflow: dividend=0x8000_0000_0000_0000, divisor=−1 → quotient=0x8000_0000_0000_0000, remainder=0.
- Handshake: during a 100/7 RUN, pulse start with 50/5 at cycle 10 and again in the done cycle → only one done, result 14 r 2. A start in the next IDLE yields 10 r 0 at +66.
- Reset at cycle 30 of a run → all outputs 0 that cycle, no done. A fresh 0xFFFF_FFFF_FFFF_FFFF / 1 (unsigned) then completes with quotient=all-ones, remainder=0.
